// File: rtl/cpu_pkg.sv
// Shared CPU definitions: arbiter state encoding, memory-port owner ids and
// default bus widths used by the memory port arbiter and its helpers.
package cpu_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Which requester currently owns the memory port
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Fixed-priority selection: the data port always beats the fetch port
    function automatic owner_t pick_owner(input logic dm_eligible);
        owner_t result;
        if (dm_eligible) begin
            result = OWN_DM;
        end else begin
            result = OWN_IF;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with enable. Sticks at all-ones instead of wrapping
// so long stalls never read back as short ones.
module sat_counter
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] COUNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(32'd1);

    // Count enabled cycles, holding at the maximum value
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= COUNT_ZERO;
        end else if (enable && (count != COUNT_MAX)) begin
            count <= count + COUNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: sole master of the unified instruction/data memory.
// Serialises instruction fetches (IF) and loads/stores (DM) onto a single
// memory port, one access at a time, and counts fetch stall cycles.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_ack,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    input  logic                  halt,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic [31:0]           if_wait_cycles
);

    // Down-counter width: must hold MEM_LATENCY, at least one bit
    localparam int LAT_W = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_ZERO = LAT_W'(32'd0);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(32'd1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    arb_state_t       state;
    owner_t           owner;
    logic             acc_we;
    logic [LAT_W-1:0] lat_cnt;
    logic             halted;
    logic             if_eligible;
    logic             grant_valid;
    owner_t           grant_owner;
    logic             wait_count_en;

    // Remember that HLT was seen; only reset can clear it, so a glitch on
    // halt cannot re-enable fetching.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            halted <= 1'b0;
        end else if (halt) begin
            halted <= 1'b1;
        end else begin
            halted <= halted;
        end
    end

    // Decide whether a request can be granted this cycle and who gets it
    always_comb begin
        if_eligible = if_req && !halt && !halted;
        grant_valid = 1'b0;
        grant_owner = OWN_IF;
        if (dm_req || if_eligible) begin
            grant_valid = 1'b1;
            grant_owner = pick_owner(dm_req);
        end else begin
            grant_valid = 1'b0;
            grant_owner = OWN_IF;
        end
    end

    // Sequencer: grant in IDLE, wait out the memory latency, pulse the ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            acc_we    <= 1'b0;
            lat_cnt   <= LAT_ZERO;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= ADDR_ZERO;
            mem_wdata <= DATA_ZERO;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= DATA_ZERO;
            dm_rdata  <= DATA_ZERO;
            busy      <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    if (grant_valid) begin
                        state   <= ARB_ACCESS;
                        owner   <= grant_owner;
                        lat_cnt <= LAT_LOAD;
                        mem_en  <= 1'b1;
                        busy    <= 1'b1;
                        if (grant_owner == OWN_DM) begin
                            acc_we    <= dm_we;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            acc_we    <= 1'b0;
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= DATA_ZERO;
                        end
                    end else begin
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                ARB_ACCESS: begin
                    // The strobe is a single cycle; the rest is waiting
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (lat_cnt == LAT_ZERO) begin
                        state <= ARB_RESP;
                        if (owner == OWN_DM) begin
                            dm_ack <= 1'b1;
                            // A store leaves the previous load result intact
                            if (!acc_we) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                dm_rdata <= dm_rdata;
                            end
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_ONE;
                    end
                end
                ARB_RESP: begin
                    // No grant on this edge: requesters update their
                    // request during the ack cycle.
                    state  <= ARB_IDLE;
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state  <= ARB_IDLE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // A fetch is stalled whenever it is requested but not being acked
    always_comb begin
        wait_count_en = if_req && !if_ack;
    end

    sat_counter #(
        .WIDTH (32)
    ) u_if_wait_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (wait_count_en),
        .count  (if_wait_cycles)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Two instances (memory latency 1
// and 3), each with a behavioural memory, driven by directed and random
// transactions and compared against a transaction-level expectation model.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset          [2];
    logic        if_req         [2];
    logic [31:0] if_addr        [2];
    logic        if_ack         [2];
    logic [31:0] if_rdata       [2];
    logic        dm_req         [2];
    logic        dm_we          [2];
    logic [31:0] dm_addr        [2];
    logic [31:0] dm_wdata       [2];
    logic        dm_ack         [2];
    logic [31:0] dm_rdata       [2];
    logic        halt           [2];
    logic        mem_en         [2];
    logic        mem_we         [2];
    logic [31:0] mem_addr       [2];
    logic [31:0] mem_wdata      [2];
    logic [31:0] mem_rdata      [2];
    logic        busy           [2];
    logic [31:0] if_wait_cycles [2];

    int tests = 0;
    int fails = 0;

    // Expectation model state
    bit [31:0] ref_mem  [2][256];
    bit        ref_wr   [2][256];
    logic [31:0] ref_dm_rd [2];
    logic [31:0] ref_wait  [2];

    // Contents of a never-written memory word
    function automatic logic [31:0] fill(input logic [7:0] idx);
        return {idx, ~idx, idx ^ 8'h5A, 8'hC3};
    endfunction

    function automatic logic [31:0] ref_read(input int k, input logic [31:0] a);
        logic [7:0] idx;
        idx = a[9:2];
        return ref_wr[k][idx] ? ref_mem[k][idx] : fill(idx);
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        bit [31:0]   dmem [256];
        bit          dwr  [256];
        logic [31:0] pipe [3];

        mem_port_arbiter #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .MEM_LATENCY (LAT)
        ) dut (
            .clock          (clock),
            .reset          (reset[g]),
            .if_req         (if_req[g]),
            .if_addr        (if_addr[g]),
            .if_ack         (if_ack[g]),
            .if_rdata       (if_rdata[g]),
            .dm_req         (dm_req[g]),
            .dm_we          (dm_we[g]),
            .dm_addr        (dm_addr[g]),
            .dm_wdata       (dm_wdata[g]),
            .dm_ack         (dm_ack[g]),
            .dm_rdata       (dm_rdata[g]),
            .halt           (halt[g]),
            .mem_en         (mem_en[g]),
            .mem_we         (mem_we[g]),
            .mem_addr       (mem_addr[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_rdata      (mem_rdata[g]),
            .busy           (busy[g]),
            .if_wait_cycles (if_wait_cycles[g])
        );

        // Synchronous memory: samples the strobe, read data LAT edges later;
        // junk on the bus otherwise so a wrong capture edge is visible.
        always @(posedge clock) begin
            if (mem_en[g] && mem_we[g]) begin
                dmem[mem_addr[g][9:2]] <= mem_wdata[g];
                dwr[mem_addr[g][9:2]]  <= 1'b1;
            end
            pipe[0] <= (mem_en[g] && !mem_we[g]) ?
                       (dwr[mem_addr[g][9:2]] ? dmem[mem_addr[g][9:2]] : fill(mem_addr[g][9:2])) :
                       $urandom;
            for (int j = 1; j < 3; j++) pipe[j] <= pipe[j-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction set: optional fetch and/or data access issued together
    task automatic run_txn(input int k, input bit do_if, input bit do_dm, input bit we,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                           input bit late_if, input bit late_dm, input int halt_t);
        int L, P, N, n_acc, en_cnt, ifa_cnt, dma_cnt, ifa_t, dma_t, bad_we, dbl, exp_if_t;
        bit acc_dm [2];
        bit if_served, drop_if_next, drop_dm_next;
        int en_t [2];
        logic [31:0] en_addr [2];
        logic        en_we   [2];
        logic [31:0] en_wd   [2];
        logic [31:0] if_rd_obs, dm_rd_obs, wait_at_ack, wait_end, exp_if_rd, exp_dm_rd, base;
        L = (k == 0) ? 1 : 3;
        P = L + 3;
        N = 2 * P + 4;
        n_acc = 0;
        if_served = 1'b0;
        exp_if_t = 0;
        exp_dm_rd = ref_dm_rd[k];
        if (do_dm) begin
            acc_dm[n_acc] = 1'b1;
            n_acc++;
            if (we) begin
                ref_mem[k][da[9:2]] = wd;
                ref_wr[k][da[9:2]]  = 1'b1;
            end else begin
                exp_dm_rd = ref_read(k, da);
            end
        end
        if (do_if && !halt[k] && (halt_t < 0 || halt_t > n_acc * P)) begin
            acc_dm[n_acc] = 1'b0;
            if_served = 1'b1;
            exp_if_t = 1 + n_acc * P + L + 1;
            n_acc++;
        end
        exp_if_rd = ref_read(k, ia);
        base = ref_wait[k];
        en_cnt = 0; ifa_cnt = 0; dma_cnt = 0; ifa_t = -1; dma_t = -1; bad_we = 0; dbl = 0;
        drop_if_next = 1'b0; drop_dm_next = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en_t[i] = -1; en_addr[i] = 'x; en_we[i] = 1'bx; en_wd[i] = 'x;
        end
        if_rd_obs = 'x; dm_rd_obs = 'x; wait_at_ack = 'x;

        @(negedge clock);
        if_req[k] = do_if; if_addr[k] = ia;
        dm_req[k] = do_dm; dm_we[k] = we; dm_addr[k] = da; dm_wdata[k] = wd;
        if (halt_t == 0) halt[k] = 1'b1;
        for (int t = 1; t <= N; t++) begin
            @(negedge clock);
            if (mem_en[k]) begin
                if (en_cnt < 2) begin
                    en_t[en_cnt] = t; en_addr[en_cnt] = mem_addr[k];
                    en_we[en_cnt] = mem_we[k]; en_wd[en_cnt] = mem_wdata[k];
                end
                en_cnt++;
            end
            if (!mem_en[k] && mem_we[k]) bad_we++;
            if (if_ack[k] && dm_ack[k]) dbl++;
            if (if_ack[k]) begin
                ifa_cnt++; ifa_t = t; if_rd_obs = if_rdata[k]; wait_at_ack = if_wait_cycles[k];
            end
            if (dm_ack[k]) begin
                dma_cnt++; dma_t = t; dm_rd_obs = dm_rdata[k];
            end
            if (drop_if_next) begin if_req[k] = 1'b0; drop_if_next = 1'b0; end
            if (drop_dm_next) begin dm_req[k] = 1'b0; drop_dm_next = 1'b0; end
            if (if_ack[k]) begin
                if (late_if) drop_if_next = 1'b1; else if_req[k] = 1'b0;
            end
            if (dm_ack[k]) begin
                if (late_dm) drop_dm_next = 1'b1; else dm_req[k] = 1'b0;
            end
            if (t == halt_t) halt[k] = 1'b1;
        end
        wait_end = if_wait_cycles[k];
        if_req[k] = 1'b0;
        dm_req[k] = 1'b0;

        check($sformatf("k%0d en_count", k), 32'(en_cnt), 32'(n_acc));
        for (int i = 0; i < n_acc; i++) begin
            check($sformatf("k%0d en_time%0d", k, i), 32'(en_t[i]), 32'(1 + i * P));
            check($sformatf("k%0d en_addr%0d", k, i), en_addr[i], acc_dm[i] ? da : ia);
            check($sformatf("k%0d en_we%0d", k, i), 32'(en_we[i]), 32'(acc_dm[i] && we));
            if (acc_dm[i] && we) check($sformatf("k%0d en_wdata%0d", k, i), en_wd[i], wd);
        end
        check($sformatf("k%0d if_ack_count", k), 32'(ifa_cnt), 32'(if_served));
        if (if_served) begin
            check($sformatf("k%0d if_ack_time", k), 32'(ifa_t), 32'(exp_if_t));
            check($sformatf("k%0d if_rdata", k), if_rd_obs, exp_if_rd);
            check($sformatf("k%0d wait_at_ack", k), wait_at_ack, base + 32'(exp_if_t));
        end
        check($sformatf("k%0d dm_ack_count", k), 32'(dma_cnt), 32'(do_dm));
        if (do_dm) begin
            check($sformatf("k%0d dm_ack_time", k), 32'(dma_t), 32'(L + 2));
            check($sformatf("k%0d dm_rdata", k), dm_rd_obs, exp_dm_rd);
        end
        check($sformatf("k%0d we_without_en", k), 32'(bad_we), 32'd0);
        check($sformatf("k%0d double_ack", k), 32'(dbl), 32'd0);
        ref_wait[k] = base + (if_served ? 32'(exp_if_t) : (do_if ? 32'(N) : 32'd0));
        check($sformatf("k%0d wait_end", k), wait_end, ref_wait[k]);
        check($sformatf("k%0d busy_end", k), 32'(busy[k]), 32'd0);
        ref_dm_rd[k] = exp_dm_rd;
    endtask

    // Two fetches back to back: the requester swaps the address in the ack cycle
    task automatic fetch_pair(input int k, input logic [31:0] a0, input logic [31:0] a1);
        int L, P, N, n_en, n_ack;
        int en_t [2];
        logic [31:0] en_addr [2];
        int ack_t [2];
        logic [31:0] ack_d [2];
        logic [31:0] ack_w [2];
        logic [31:0] d0, d1, base;
        L = (k == 0) ? 1 : 3;
        P = L + 3;
        N = 2 * P + 4;
        d0 = ref_read(k, a0);
        d1 = ref_read(k, a1);
        base = ref_wait[k];
        n_en = 0; n_ack = 0;
        for (int i = 0; i < 2; i++) begin
            en_t[i] = -1; en_addr[i] = 'x; ack_t[i] = -1; ack_d[i] = 'x; ack_w[i] = 'x;
        end
        @(negedge clock);
        if_req[k] = 1'b1; if_addr[k] = a0; dm_req[k] = 1'b0;
        for (int t = 1; t <= N; t++) begin
            @(negedge clock);
            if (mem_en[k]) begin
                if (n_en < 2) begin en_t[n_en] = t; en_addr[n_en] = mem_addr[k]; end
                n_en++;
            end
            if (if_ack[k]) begin
                if (n_ack < 2) begin
                    ack_t[n_ack] = t; ack_d[n_ack] = if_rdata[k]; ack_w[n_ack] = if_wait_cycles[k];
                end
                n_ack++;
                if (n_ack == 1) if_addr[k] = a1; else if_req[k] = 1'b0;
            end
        end
        if_req[k] = 1'b0;
        check($sformatf("k%0d pair_en_count", k), 32'(n_en), 32'd2);
        check($sformatf("k%0d pair_ack_count", k), 32'(n_ack), 32'd2);
        check($sformatf("k%0d pair_en0_time", k), 32'(en_t[0]), 32'd1);
        check($sformatf("k%0d pair_en1_time", k), 32'(en_t[1]), 32'(1 + P));
        check($sformatf("k%0d pair_addr0", k), en_addr[0], a0);
        check($sformatf("k%0d pair_addr1", k), en_addr[1], a1);
        check($sformatf("k%0d pair_ack0_time", k), 32'(ack_t[0]), 32'(L + 2));
        check($sformatf("k%0d pair_ack_spacing", k), 32'(ack_t[1] - ack_t[0]), 32'(P));
        check($sformatf("k%0d pair_data0", k), ack_d[0], d0);
        check($sformatf("k%0d pair_data1", k), ack_d[1], d1);
        check($sformatf("k%0d pair_wait1", k), ack_w[1], base + 32'(2 * L + 4));
        ref_wait[k] = base + 32'(2 * L + 4);
    endtask

    task automatic do_reset(input int k);
        @(negedge clock);
        reset[k] = 1'b1; if_req[k] = 1'b0; dm_req[k] = 1'b0; halt[k] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset[k] = 1'b0;
        ref_wait[k] = 32'd0;
        ref_dm_rd[k] = 32'd0;
        check($sformatf("k%0d rst_wait", k), if_wait_cycles[k], 32'd0);
        check($sformatf("k%0d rst_dm_rdata", k), dm_rdata[k], 32'd0);
        check($sformatf("k%0d rst_if_rdata", k), if_rdata[k], 32'd0);
    endtask

    // Reset while the strobe is out: outputs drop at once, nothing is acked
    task automatic reset_mid(input int k);
        int events;
        @(negedge clock);
        if_req[k] = 1'b1; if_addr[k] = $urandom; dm_req[k] = 1'b0;
        @(negedge clock);
        check($sformatf("k%0d mid_en_before", k), 32'(mem_en[k]), 32'd1);
        check($sformatf("k%0d mid_busy_before", k), 32'(busy[k]), 32'd1);
        #2 reset[k] = 1'b1;
        #1;
        check($sformatf("k%0d mid_en_async", k), 32'(mem_en[k]), 32'd0);
        check($sformatf("k%0d mid_busy_async", k), 32'(busy[k]), 32'd0);
        if_req[k] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset[k] = 1'b0; halt[k] = 1'b0;
        events = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            if (if_ack[k] || dm_ack[k] || mem_en[k]) events++;
        end
        check($sformatf("k%0d mid_no_ack_after", k), 32'(events), 32'd0);
        check($sformatf("k%0d mid_wait", k), if_wait_cycles[k], 32'd0);
        ref_wait[k] = 32'd0;
        ref_dm_rd[k] = 32'd0;
    endtask

    initial begin
        int sel;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; if_req[k] = 1'b1; dm_req[k] = 1'b1; halt[k] = 1'b0;
            if_addr[k] = 32'h0; dm_we[k] = 1'b0; dm_addr[k] = 32'h0; dm_wdata[k] = 32'h0;
            ref_wait[k] = 32'd0; ref_dm_rd[k] = 32'd0;
        end

        // Reset held with both requests active
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("k%0d reset_mem_en", k), 32'(mem_en[k]), 32'd0);
                check($sformatf("k%0d reset_busy", k), 32'(busy[k]), 32'd0);
                check($sformatf("k%0d reset_acks", k), 32'(if_ack[k] | dm_ack[k]), 32'd0);
                check($sformatf("k%0d reset_wait", k), if_wait_cycles[k], 32'd0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; dm_req[k] = 1'b0; reset[k] = 1'b0;
        end

        for (int k = 0; k < 2; k++) begin
            // Plain store then fetch of the stored word
            run_txn(k, 1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, -1);
            run_txn(k, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1'b0, -1);
            // Collision from reset: data port first, fetch next
            do_reset(k);
            run_txn(k, 1'b1, 1'b1, 1'b1, 32'h20, 32'h100, 32'h5, 1'b0, 1'b0, -1);
            run_txn(k, 1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0, 1'b0, 1'b1, -1);
            fetch_pair(k, 32'h0, 32'h4);
            // Random traffic
            for (int r = 0; r < 10; r++) begin
                sel = $urandom_range(1, 3);
                run_txn(k, sel[0], sel[1], 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            end
            // Halt: only the load is served, then nothing while halted
            run_txn(k, 1'b1, 1'b1, 1'b0, $urandom, 32'h40, 32'h0, 1'b0, 1'b0, 0);
            run_txn(k, 1'b1, 1'b0, 1'b0, $urandom, 32'h0, 32'h0, 1'b0, 1'b0, -1);
            // Halt raised after a fetch grant: the fetch still completes
            do_reset(k);
            run_txn(k, 1'b1, 1'b0, 1'b0, $urandom, 32'h0, 32'h0, 1'b0, 1'b0, 2);
            do_reset(k);
            // Reset mid-access, then a clean restart
            reset_mid(k);
            run_txn(k, 1'b1, 1'b0, 1'b0, $urandom, 32'h0, 32'h0, 1'b0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
